imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 176 +++++++++++++++++
 tb/tb_imem_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed byte image into instruction memory.
// The datapath is held in reset (cpu_rst) until the image has been written.
// Stream format: length byte (0 means 2^DATA_W bytes), payload, then an
// optional checksum byte.
// Build option: define IMEM_LOADER_CHECKSUM_EN to enable the trailing
// checksum byte. The checksum is the 8-bit sum of the payload. A mismatch
// sets load_err and returns the loader to the length-wait state.
module imem_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  // One extra bit so that a length byte of 0 can represent the full 2^DATA_W count.
  localparam int unsigned CNT_W = DATA_W + 1;

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM = 2'd2,
`endif
    S_DONE = 2'd3
  } t_state;

  t_state            r_state;
  t_state            w_next;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_last;

  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_rst;
  logic              r_load_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic              r_load_err;
`endif

  assign w_accept = in_valid && w_in_ready;
  assign w_last   = (r_cnt == CNT_W'(1));

  assign in_ready  = w_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_rst   = r_cpu_rst;
  assign load_done = r_load_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign load_err  = r_load_err;
`else
  assign load_err  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LEN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and ready generation; only DONE refuses bytes.
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b1;
    case (r_state)
      S_LEN: begin
        if (w_accept) w_next = S_DATA;
      end
      S_DATA: begin
        if (w_accept && w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next = S_CSUM;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept) w_next = (in_data == r_sum) ? S_DONE : S_LEN;
      end
`endif
      S_DONE: begin
        w_in_ready = 1'b0;
        if (reload) w_next = S_LEN;
      end
      default: begin
        w_next = S_LEN;
      end
    endcase
  end

  // Datapath: counters, registered write port and status flags.
  // cpu_rst and load_done change on the first edge seen in DONE. That edge
  // also retires the final write strobe, so cpu_rst never drops while a
  // mem_we pulse is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rst   <= 1'b1;
      r_load_done <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum       <= '0;
      r_load_err  <= 1'b0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_LEN: begin
          if (w_accept) begin
            r_cnt <= (in_data == '0) ? {1'b1, {DATA_W{1'b0}}} : {1'b0, in_data};
            r_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum      <= '0;
            r_load_err <= 1'b0;
`endif
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_idx;
            r_mem_wdata <= in_data;
            r_idx       <= r_idx + ADDR_W'(1);
            r_cnt       <= r_cnt - CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum       <= r_sum + in_data;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_accept && (in_data != r_sum)) r_load_err <= 1'b1;
        end
`endif
        S_DONE: begin
          if (reload) begin
            r_cpu_rst   <= 1'b1;
            r_load_done <= 1'b0;
          end else begin
            r_cpu_rst   <= 1'b0;
            r_load_done <= 1'b1;
          end
        end
        default: begin
          r_cpu_rst   <= 1'b1;
          r_load_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (default build, checksum disabled).
module tb_imem_loader;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       reload;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_rst;
  logic       load_done;
  logic       load_err;

  int unsigned n_checks;
  int unsigned n_fail;

  imem_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [7:0] a, input logic [7:0] d);
    chk({tag, "_we"}, 32'(mem_we), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_data"}, 32'(mem_wdata), 32'(d));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);

    // Stream 03,11,22,33 back-to-back
    in_valid = 1'b1; in_data = 8'h03; tick();
    chk("s1_len_no_we", 32'(mem_we), 32'd0);
    in_data = 8'h11; tick();
    chk_wr("s1_w0", 8'h00, 8'h11);
    in_data = 8'h22; tick();
    chk_wr("s1_w1", 8'h01, 8'h22);
    in_data = 8'h33; tick();
    chk_wr("s1_w2", 8'h02, 8'h33);
    chk("s1_cpu_rst_during_last_we", 32'(cpu_rst), 32'd1);
    chk("s1_ready_done", 32'(in_ready), 32'd0);
    in_valid = 1'b0; tick();
    chk("s1_we_off", 32'(mem_we), 32'd0);
    chk("s1_cpu_rst_fall", 32'(cpu_rst), 32'd0);
    chk("s1_done", 32'(load_done), 32'd1);
    chk("s1_addr_hold", 32'(mem_addr), 32'h02);
    chk("s1_data_hold", 32'(mem_wdata), 32'h33);

    // DONE ignores in_valid, then reload and stream 01,55
    in_valid = 1'b1; in_data = 8'h99; tick();
    chk("s2_ign_we", 32'(mem_we), 32'd0);
    chk("s2_ign_ready", 32'(in_ready), 32'd0);
    chk("s2_ign_done", 32'(load_done), 32'd1);
    in_valid = 1'b0; reload = 1'b1; tick();
    reload = 1'b0;
    chk("s2_reload_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("s2_reload_done", 32'(load_done), 32'd0);
    chk("s2_reload_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 8'h01; tick();
    in_data = 8'h55; tick();
    chk_wr("s2_w0", 8'h00, 8'h55);
    chk("s2_cpu_rst_hi", 32'(cpu_rst), 32'd1);
    in_valid = 1'b0; tick();
    chk("s2_we_off", 32'(mem_we), 32'd0);
    chk("s2_cpu_rst_fall", 32'(cpu_rst), 32'd0);
    chk("s2_done", 32'(load_done), 32'd1);

    // Length 02, data 0A, 3-cycle gap (with an ignored reload), data 0B
    reload = 1'b1; tick();
    reload = 1'b0;
    in_valid = 1'b1; in_data = 8'h02; tick();
    in_data = 8'h0A; tick();
    chk_wr("s3_w0", 8'h00, 8'h0A);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) reload = 1'b1;
      tick();
      reload = 1'b0;
      chk($sformatf("s3_gap%0d_we", i), 32'(mem_we), 32'd0);
      chk($sformatf("s3_gap%0d_addr", i), 32'(mem_addr), 32'h00);
      chk($sformatf("s3_gap%0d_ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b1; in_data = 8'h0B; tick();
    chk_wr("s3_w1", 8'h01, 8'h0B);
    in_valid = 1'b0; tick();
    chk("s3_we_off", 32'(mem_we), 32'd0);
    chk("s3_cpu_rst_fall", 32'(cpu_rst), 32'd0);
    chk("s3_done", 32'(load_done), 32'd1);

    // Reset mid-load after 2 of 4 bytes, then stream 01,7F
    reload = 1'b1; tick();
    reload = 1'b0;
    in_valid = 1'b1; in_data = 8'h04; tick();
    in_data = 8'hAA; tick();
    chk_wr("s4_w0", 8'h00, 8'hAA);
    in_data = 8'hBB; tick();
    chk_wr("s4_w1", 8'h01, 8'hBB);
    in_valid = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    chk("s4_rst_we", 32'(mem_we), 32'd0);
    chk("s4_rst_addr", 32'(mem_addr), 32'd0);
    chk("s4_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("s4_rst_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 8'h01; tick();
    chk("s4_len_no_we", 32'(mem_we), 32'd0);
    in_data = 8'h7F; tick();
    chk_wr("s4_w7f", 8'h00, 8'h7F);
    chk("s4_cpu_rst_hi", 32'(cpu_rst), 32'd1);
    in_valid = 1'b0; tick();
    chk("s4_we_off", 32'(mem_we), 32'd0);
    chk("s4_cpu_rst_fall", 32'(cpu_rst), 32'd0);
    chk("s4_done", 32'(load_done), 32'd1);

    // Length 00 -> 256 bytes of value i
    reload = 1'b1; tick();
    reload = 1'b0;
    in_valid = 1'b1; in_data = 8'h00; tick();
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("s5_ready%0d", i), 32'(in_ready), 32'd1);
      in_data = 8'(i);
      tick();
      chk_wr($sformatf("s5_w%0d", i), 8'(i), 8'(i));
    end
    chk("s5_ready_done", 32'(in_ready), 32'd0);
    in_valid = 1'b0; tick();
    chk("s5_we_off", 32'(mem_we), 32'd0);
    chk("s5_addr_hold", 32'(mem_addr), 32'hFF);
    chk("s5_cpu_rst_fall", 32'(cpu_rst), 32'd0);
    chk("s5_done", 32'(load_done), 32'd1);
    chk("s5_err", 32'(load_err), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
